seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Multi-cycle restoring divider: the inverse of the combinational a*b multiplier.
//  It computes quotient and remainder of dividend/divisor one bit per clock,
//  in unsigned or two's-complement signed mode.
//  It sits beside the multiplier in the datapath and is controlled by a start/done handshake.
// PARAMETERS
//  WIDTH   4   operand, quotient and remainder width in bits (>=2)
//  SIGNED  0   0 = unsigned divide; 1 = two's-complement signed divide
// PORTS
//  clk          in   1      rising-edge clock
//  reset_n      in   1      synchronous, active-low reset
//  start        in   1      request a divide; accepted only in IDLE
//  dividend     in   WIDTH  numerator, sampled on the accepting edge
//  divisor      in   WIDTH  denominator, sampled on the accepting edge
//  busy         out  1      high while in RUN or FIX
//  done         out  1      one-cycle pulse; results valid from this cycle
//  quotient     out  WIDTH  result quotient; held until the next accepted start
//  remainder    out  WIDTH  result remainder; held until the next accepted start
//  div_by_zero  out  1      divisor was 0; valid and held with quotient
// BEHAVIOUR
//  Reset: reset_n low at a clk edge -> state IDLE; busy, done, quotient, remainder,
//   div_by_zero all 0; iteration counter 0. Applies in any state, including mid-RUN.
//   The aborted operation produces no done.
//  FSM states: IDLE, RUN, FIX, DONE.
//   IDLE --start--> RUN: latch operands. If SIGNED, latch magnitudes and both sign bits.
//   RUN: WIDTH iterations, counter WIDTH-1 down to 0.
//    Each iteration: rem = {rem[WIDTH-1:0], dvd_msb}; shift dvd left.
//    If rem >= dsr: rem -= dsr and shift in quotient bit 1; else shift in 0.
//    The partial remainder is WIDTH+1 bits, so the compare/subtract never overflows.
//   RUN --(counter==0)--> FIX.
//   FIX: sign correction, then register outputs. FIX --> DONE.
//   DONE: done=1 for exactly one cycle; DONE --> IDLE.
//  Latency: start sampled at edge E0.
//   RUN occupies edges E1..E_WIDTH; FIX occupies E_WIDTH+1.
//   done is high in the cycle after E_WIDTH+1 (WIDTH+2 edges after start; 6 for WIDTH=4).
//   Back-to-back throughput: one divide per WIDTH+3 cycles.
//  Handshake rules:
//   start is ignored in RUN, FIX and DONE; operand changes in those states have no effect.
//   busy=0 in IDLE and DONE.
//   Outputs change only on the FIX->DONE edge or on reset.
//  Signed mode (SIGNED=1): truncate toward zero.
//   quotient is negative iff the operand signs differ.
//   remainder takes the dividend's sign.
//   Invariant: quotient*divisor + remainder == dividend (mod 2^WIDTH).
//   Magnitude of -2^(WIDTH-1) is held in WIDTH+1 bits, so there is no internal overflow.
//   -2^(WIDTH-1) / -1 -> quotient = -2^(WIDTH-1) (wraps), remainder 0, div_by_zero 0.
//  Divide by zero: full latency still taken.
//   quotient = all ones; remainder = dividend (unmodified, either mode); div_by_zero=1.
//  Zero dividend: quotient 0, remainder 0.
// TESTING
//  1 Unsigned W=4: 13/3 -> quotient 4, remainder 1, div_by_zero 0.
//    done exactly 6 edges after start; busy high for 5 cycles.
//  2 Unsigned 15/0 -> quotient 4'hF, remainder 4'hF, div_by_zero 1, same latency.
//    A following 8/2 -> quotient 4, remainder 0, div_by_zero cleared.
//  3 Signed W=4: -7/2 -> q 4'hD (-3), r 4'hF (-1).
//    7/-2 -> q 4'hD, r 4'h1.
//    -8/-1 -> q 4'h8, r 4'h0.
//  4 start re-pulsed in RUN with 9/9: ignored; the first op's result is returned
//    with a single done pulse.
//    reset_n low mid-RUN -> next edge busy 0, outputs 0, no done.
//  5 Exhaustive, both modes, all 256 operand pairs, driven back-to-back on done.
//    Non-zero divisor: check q*b + r == a, |r| < |b|, and sign rules.
//    Zero divisor: check the divide-by-zero rule.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, unsigned or
// two's-complement signed, with a start/done handshake.
module seq_divider #(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             accept;

  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   dsr;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvd_raw;
  logic             neg_a;
  logic             neg_b;
  logic             dz;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1), which
  // still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] m;
    m = (SIGNED && v[WIDTH-1]) ? -v : v;
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m, input logic neg);
    return neg ? (~m + 1'b1) : m;
  endfunction

  assign accept = (state == IDLE) && start;

  always_comb begin
    rem_sh  = (rem << 1) | {{WIDTH{1'b0}}, dvd[WIDTH-1]};
    q_bit   = (rem_sh >= dsr);
    rem_nxt = q_bit ? (rem_sh - dsr) : rem_sh;
  end

  // Divide by zero bypasses sign correction: all-ones quotient, raw dividend.
  always_comb begin
    q_fix = dz ? {WIDTH{1'b1}} : apply_sign(dvd, neg_a ^ neg_b);
    r_fix = dz ? dvd_raw       : apply_sign(rem[WIDTH-1:0], neg_a);
  end

  // Operand capture and shift/subtract iterations
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd     <= magnitude(dividend);
      dsr     <= {1'b0, magnitude(divisor)};
      rem     <= '0;
      dvd_raw <= dividend;
      neg_a   <= SIGNED & dividend[WIDTH-1];
      neg_b   <= SIGNED & divisor[WIDTH-1];
      dz      <= (divisor == '0);
    end else if (state == RUN) begin
      rem <= rem_nxt;
      dvd <= {dvd[WIDTH-2:0], q_bit};
    end
  end

  // Control state, iteration counter and result registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= CW'(WIDTH - 1);
      else if ((state == RUN) && (cnt != '0))
        cnt <= cnt - CW'(1);
      if (state == FIX) begin
        quotient    <= q_fix;
        remainder   <= r_fix;
        div_by_zero <= dz;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: unsigned and signed instances side by side,
// checked against plain integer division.
module tb_seq_divider;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         u_start, s_start;
  logic [W-1:0] u_a, u_b, s_a, s_b;
  logic         u_busy, u_done, u_dz, s_busy, s_done, s_dz;
  logic [W-1:0] u_q, u_r, s_q, s_r;

  typedef struct {
    logic [3:0] a, b, q, r;
    logic       dz;
  } txn_t;

  txn_t       uq[$];
  txn_t       sq[$];
  logic [3:0] last_q[2];
  int         n_checks = 0;
  int         n_fail   = 0;

  seq_divider #(.WIDTH(W), .SIGNED(1'b0)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(u_start), .dividend(u_a), .divisor(u_b),
    .busy(u_busy), .done(u_done), .quotient(u_q), .remainder(u_r), .div_by_zero(u_dz)
  );

  seq_divider #(.WIDTH(W), .SIGNED(1'b1)) s_dut (
    .clk(clk), .reset_n(reset_n), .start(s_start), .dividend(s_a), .divisor(s_b),
    .busy(s_busy), .done(s_done), .quotient(s_q), .remainder(s_r), .div_by_zero(s_dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: integer division truncating toward zero.
  function automatic txn_t model(input bit sm, input logic [3:0] a, input logic [3:0] b);
    txn_t t;
    int sa, sb, q, r;
    t.a = a;
    t.b = b;
    if (b == 4'd0) begin
      t.q  = 4'hF;
      t.r  = a;
      t.dz = 1'b1;
      return t;
    end
    sa   = sm ? int'($signed(a)) : int'(a);
    sb   = sm ? int'($signed(b)) : int'(b);
    q    = sa / sb;
    r    = sa % sb;
    t.q  = q[3:0];
    t.r  = r[3:0];
    t.dz = 1'b0;
    return t;
  endfunction

  function automatic int sval(input bit sm, input logic [3:0] v);
    int x;
    x = sm ? int'($signed(v)) : int'(v);
    return (x < 0) ? -x : x;
  endfunction

  task automatic mon(input bit sm, input logic [3:0] q, input logic [3:0] r, input logic dz);
    txn_t       t;
    logic [31:0] p;
    if ((sm && sq.size() == 0) || (!sm && uq.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_done mode=%0d: got done with q=%h r=%h, expected no done", sm, q, r);
      return;
    end
    if (sm) t = sq.pop_front();
    else    t = uq.pop_front();
    check($sformatf("quotient m%0d %h/%h", sm, t.a, t.b), q, t.q);
    check($sformatf("remainder m%0d %h/%h", sm, t.a, t.b), r, t.r);
    check($sformatf("div_by_zero m%0d %h/%h", sm, t.a, t.b), dz, t.dz);
    if (t.b != 4'd0) begin
      p = (32'(q) * 32'(t.b) + 32'(r)) & 32'hF;
      check($sformatf("q*b+r m%0d %h/%h", sm, t.a, t.b), p, 32'(t.a));
      check($sformatf("rem_bound m%0d %h/%h", sm, t.a, t.b),
            32'(sval(sm, r) < sval(sm, t.b)), 32'd1);
      if (sm && r != 4'd0)
        check($sformatf("rem_sign %h/%h", t.a, t.b), r[3], t.a[3]);
    end
  endtask

  always @(negedge clk) begin
    if (u_done) mon(1'b0, u_q, u_r, u_dz);
    if (s_done) mon(1'b1, s_q, s_r, s_dz);
  end

  task automatic drive(input bit sm, input logic st, input logic [3:0] a, input logic [3:0] b);
    if (sm) begin s_start = st; s_a = a; s_b = b; end
    else    begin u_start = st; u_a = a; u_b = b; end
  endtask

  // Called just after a posedge with the DUT in IDLE; returns with it back in IDLE.
  task automatic do_op(input bit sm, input logic [3:0] a, input logic [3:0] b,
                       input bit repulse, output int lat, output int bc);
    txn_t       t;
    logic       dn, bz;
    logic [3:0] qo;
    t   = model(sm, a, b);
    lat = 0;
    bc  = 0;
    dn  = 1'b0;
    if (sm) sq.push_back(t);
    else    uq.push_back(t);
    drive(sm, 1'b1, a, b);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) drive(sm, 1'b0, 4'($urandom), 4'($urandom));
      if (repulse && lat == 2) drive(sm, 1'b1, 4'd9, 4'd9);
      if (repulse && lat == 3) drive(sm, 1'b0, 4'd9, 4'd9);
      dn = sm ? s_done : u_done;
      bz = sm ? s_busy : u_busy;
      qo = sm ? s_q : u_q;
      if (lat == 1) check($sformatf("held_quotient m%0d", sm), qo, last_q[sm]);
      if (dn) break;
      if (bz) bc++;
    end
    if (!dn) check($sformatf("done_timeout m%0d %h/%h", sm, a, b), 32'd0, 32'd1);
    else     check($sformatf("latency m%0d %h/%h", sm, a, b), lat, 6);
    last_q[sm] = t.q;
    @(posedge clk);
    #1;
  endtask

  task automatic abort_op(input bit sm, input logic [3:0] a, input logic [3:0] b);
    drive(sm, 1'b1, a, b);
    @(posedge clk); #1;
    drive(sm, 1'b0, a, b);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check($sformatf("abort_busy m%0d", sm),  sm ? s_busy : u_busy, 0);
    check($sformatf("abort_done m%0d", sm),  sm ? s_done : u_done, 0);
    check($sformatf("abort_q m%0d", sm),     sm ? s_q : u_q, 0);
    check($sformatf("abort_r m%0d", sm),     sm ? s_r : u_r, 0);
    check($sformatf("abort_dz m%0d", sm),    sm ? s_dz : u_dz, 0);
    reset_n   = 1'b1;
    last_q[0] = 4'd0;
    last_q[1] = 4'd0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, bc;
    reset_n   = 1'b0;
    last_q[0] = 4'd0;
    last_q[1] = 4'd0;
    drive(1'b0, 1'b0, 4'd0, 4'd0);
    drive(1'b1, 1'b0, 4'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy_u", u_busy, 0);
    check("reset_done_u", u_done, 0);
    check("reset_q_u", u_q, 0);
    check("reset_r_u", u_r, 0);
    check("reset_dz_u", u_dz, 0);
    check("reset_busy_s", s_busy, 0);
    check("reset_done_s", s_done, 0);
    check("reset_q_s", s_q, 0);
    check("reset_r_s", s_r, 0);
    check("reset_dz_s", s_dz, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    do_op(1'b0, 4'd13, 4'd3, 1'b0, lat, bc);
    check("busy_cycles 13/3", bc, 5);
    do_op(1'b0, 4'd15, 4'd0, 1'b0, lat, bc);
    check("busy_cycles 15/0", bc, 5);
    do_op(1'b0, 4'd8, 4'd2, 1'b0, lat, bc);

    do_op(1'b1, 4'h9, 4'h2, 1'b0, lat, bc);
    do_op(1'b1, 4'h7, 4'hE, 1'b0, lat, bc);
    do_op(1'b1, 4'h8, 4'hF, 1'b0, lat, bc);
    check("busy_cycles signed", bc, 5);

    do_op(1'b0, 4'd13, 4'd3, 1'b1, lat, bc);
    do_op(1'b1, 4'h9, 4'h2, 1'b1, lat, bc);
    repeat (10) @(posedge clk);
    #1;

    abort_op(1'b0, 4'd13, 4'd3);
    abort_op(1'b1, 4'h9, 4'h3);

    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          do_op(bit'(m), 4'(a), 4'(b), 1'b0, lat, bc);

    for (int k = 0; k < 150; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      do_op(bit'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'b0, lat, bc);
    end

    repeat (8) @(posedge clk);
    #1;
    check("u_queue_empty", uq.size(), 0);
    check("s_queue_empty", sq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
